// File: rtl/mips_exec_ctrl.sv
// Single-cycle MIPS execute-stage control: main decode, ALU control, ALU and
// one-cycle result/control register with bubble squashing of the control flags.
module mips_exec_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        bubble,
    output logic [3:0]  aluctl,
    output logic [31:0] alu_result_q,
    output logic        zero_q,
    output logic [4:0]  wrreg_q,
    output logic        regdst_q,
    output logic        branch_q,
    output logic        memread_q,
    output logic        memwrite_q,
    output logic        memtoreg_q,
    output logic        regwrite_q,
    output logic        alusrc_q
);
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;

    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    logic [15:0]   imm;
    logic          unused_rs;

    assign opcode    = instr[31:26];
    assign rt        = instr[20:16];
    assign rd        = instr[15:11];
    assign imm       = instr[15:0];
    assign funct     = instr[5:0];
    assign unused_rs = ^instr[25:21];

    logic       regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch;
    logic [1:0] aluop;

    // Main opcode decode; unknown opcodes decode to a no-op.
    always_comb begin
        regdst   = 1'b0;
        alusrc   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        branch   = 1'b0;
        aluop    = 2'b00;
        case (opcode)
            6'b000000: begin regdst = 1'b1; regwrite = 1'b1; aluop = 2'b10; end
            6'b100011: begin alusrc = 1'b1; memtoreg = 1'b1; regwrite = 1'b1; memread = 1'b1; end
            6'b101011: begin alusrc = 1'b1; memwrite = 1'b1; end
            6'b000100: begin branch = 1'b1; aluop = 2'b01; end
            6'b001000: begin alusrc = 1'b1; regwrite = 1'b1; end
            default: ;
        endcase
    end

    // ALU control from aluop and funct.
    always_comb begin
        aluctl = 4'b0000;
        case (aluop)
            2'b00: aluctl = 4'b0010;
            2'b01: aluctl = 4'b0110;
            2'b10: begin
                case (funct)
                    6'b100000: aluctl = 4'b0010;
                    6'b100010: aluctl = 4'b0110;
                    6'b100100: aluctl = 4'b0000;
                    6'b100101: aluctl = 4'b0001;
                    6'b100110: aluctl = 4'b1101;
                    6'b100111: aluctl = 4'b1100;
                    6'b101010: aluctl = 4'b0111;
                    default:   aluctl = 4'b0000;
                endcase
            end
            default: aluctl = 4'b0000;
        endcase
    end

    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_result_d;
    logic          zero_d;
    logic [RW-1:0] wrreg_d;
    logic          regdst_d, branch_d, memread_d, memwrite_d, memtoreg_d, regwrite_d, alusrc_d;

    assign alu_b = alusrc ? {{16{imm[15]}}, imm} : rt_data;

    always_comb begin
        alu_result_d = '0;
        case (aluctl)
            4'b0000: alu_result_d = rs_data & alu_b;
            4'b0001: alu_result_d = rs_data | alu_b;
            4'b0010: alu_result_d = rs_data + alu_b;
            4'b0110: alu_result_d = rs_data - alu_b;
            4'b0111: alu_result_d = DW'(($signed(rs_data) < $signed(alu_b)) ? 1 : 0);
            4'b1100: alu_result_d = ~(rs_data | alu_b);
            4'b1101: alu_result_d = rs_data ^ alu_b;
            default: alu_result_d = '0;
        endcase
    end

    // Bubble squashes only the control flags; datapath values still flow.
    always_comb begin
        zero_d     = (alu_result_d == '0);
        wrreg_d    = regdst ? rd : rt;
        regdst_d   = regdst   & ~bubble;
        branch_d   = branch   & ~bubble;
        memread_d  = memread  & ~bubble;
        memwrite_d = memwrite & ~bubble;
        memtoreg_d = memtoreg & ~bubble;
        regwrite_d = regwrite & ~bubble;
        alusrc_d   = alusrc   & ~bubble;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_result_q <= '0;
            zero_q       <= 1'b0;
            wrreg_q      <= '0;
            regdst_q     <= 1'b0;
            branch_q     <= 1'b0;
            memread_q    <= 1'b0;
            memwrite_q   <= 1'b0;
            memtoreg_q   <= 1'b0;
            regwrite_q   <= 1'b0;
            alusrc_q     <= 1'b0;
        end else begin
            alu_result_q <= alu_result_d;
            zero_q       <= zero_d;
            wrreg_q      <= wrreg_d;
            regdst_q     <= regdst_d;
            branch_q     <= branch_d;
            memread_q    <= memread_d;
            memwrite_q   <= memwrite_d;
            memtoreg_q   <= memtoreg_d;
            regwrite_q   <= regwrite_d;
            alusrc_q     <= alusrc_d;
        end
    end
endmodule

// File: tb/tb_mips_exec_ctrl.sv
// Directed table-driven bench for mips_exec_ctrl plus reset corner sequences.
module tb_mips_exec_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr, rs_data, rt_data;
    logic        bubble;
    logic [3:0]  aluctl;
    logic [31:0] alu_result_q;
    logic        zero_q;
    logic [4:0]  wrreg_q;
    logic        regdst_q, branch_q, memread_q, memwrite_q, memtoreg_q, regwrite_q, alusrc_q;

    int checks = 0;
    int errors = 0;

    mips_exec_ctrl dut (
        .clk(clk), .rst(rst), .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
        .bubble(bubble), .aluctl(aluctl), .alu_result_q(alu_result_q), .zero_q(zero_q),
        .wrreg_q(wrreg_q), .regdst_q(regdst_q), .branch_q(branch_q), .memread_q(memread_q),
        .memwrite_q(memwrite_q), .memtoreg_q(memtoreg_q), .regwrite_q(regwrite_q),
        .alusrc_q(alusrc_q)
    );

    always #5 clk = ~clk;

    // Flag order: regdst, branch, memread, memwrite, memtoreg, regwrite, alusrc
    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        bubble;
        logic [3:0]  e_aluctl;
        logic [31:0] e_res;
        logic        e_zero;
        logic [4:0]  e_wrreg;
        logic [6:0]  e_flags;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rt, input logic [5:0] fn);
        return {6'b000000, 5'd1, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm);
        return {op, 5'd2, rt, imm};
    endfunction

    function automatic logic [6:0] flags_now();
        return {regdst_q, branch_q, memread_q, memwrite_q, memtoreg_q, regwrite_q, alusrc_q};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".res"},   alu_result_q, 32'd0);
        check({tag, ".zero"},  32'(zero_q), 32'd0);
        check({tag, ".wrreg"}, 32'(wrreg_q), 32'd0);
        check({tag, ".flags"}, 32'(flags_now()), 32'd0);
    endtask

    initial begin
        vecs.push_back('{"add",   rtype(5'd3, 5'd2, 6'b100000), 32'd5, 32'd7, 1'b0, 4'b0010, 32'd12, 1'b0, 5'd3, 7'b1000010});
        vecs.push_back('{"sub",   rtype(5'd4, 5'd2, 6'b100010), 32'd5, 32'd7, 1'b0, 4'b0110, 32'hFFFFFFFE, 1'b0, 5'd4, 7'b1000010});
        vecs.push_back('{"and",   rtype(5'd5, 5'd2, 6'b100100), 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 4'b0000, 32'hF000F000, 1'b0, 5'd5, 7'b1000010});
        vecs.push_back('{"or",    rtype(5'd5, 5'd2, 6'b100101), 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 4'b0001, 32'hFFF0FFF0, 1'b0, 5'd5, 7'b1000010});
        vecs.push_back('{"xor",   rtype(5'd5, 5'd2, 6'b100110), 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 4'b1101, 32'h0FF00FF0, 1'b0, 5'd5, 7'b1000010});
        vecs.push_back('{"nor",   rtype(5'd5, 5'd2, 6'b100111), 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 4'b1100, 32'h000F000F, 1'b0, 5'd5, 7'b1000010});
        vecs.push_back('{"slt1",  rtype(5'd8, 5'd2, 6'b101010), 32'hFFFFFFFF, 32'd1, 1'b0, 4'b0111, 32'd1, 1'b0, 5'd8, 7'b1000010});
        vecs.push_back('{"slt0",  rtype(5'd8, 5'd2, 6'b101010), 32'd1, 32'hFFFFFFFF, 1'b0, 4'b0111, 32'd0, 1'b1, 5'd8, 7'b1000010});
        vecs.push_back('{"badfn", rtype(5'd9, 5'd2, 6'b000000), 32'd5, 32'd7, 1'b0, 4'b0000, 32'd5, 1'b0, 5'd9, 7'b1000010});
        vecs.push_back('{"addwrap", rtype(5'd6, 5'd2, 6'b100000), 32'hFFFFFFFF, 32'd1, 1'b0, 4'b0010, 32'd0, 1'b1, 5'd6, 7'b1000010});
        vecs.push_back('{"lw",    itype(6'b100011, 5'd9, 16'hFFFC), 32'd100, 32'd123, 1'b0, 4'b0010, 32'd96, 1'b0, 5'd9, 7'b0010111});
        vecs.push_back('{"sw",    itype(6'b101011, 5'd5, 16'h0008), 32'd1000, 32'd77, 1'b0, 4'b0010, 32'd1008, 1'b0, 5'd5, 7'b0001001});
        vecs.push_back('{"swbub", itype(6'b101011, 5'd5, 16'h0008), 32'd1000, 32'd77, 1'b1, 4'b0010, 32'd1008, 1'b0, 5'd5, 7'b0000000});
        vecs.push_back('{"beq",   itype(6'b000100, 5'd1, 16'h0010), 32'd42, 32'd42, 1'b0, 4'b0110, 32'd0, 1'b1, 5'd1, 7'b0100000});
        vecs.push_back('{"addi",  itype(6'b001000, 5'd7, 16'h8000), 32'h00010000, 32'd3, 1'b0, 4'b0010, 32'h00008000, 1'b0, 5'd7, 7'b0000011});
        vecs.push_back('{"badop", itype(6'b111111, 5'd3, 16'h1234), 32'd5, 32'd7, 1'b0, 4'b0010, 32'd12, 1'b0, 5'd3, 7'b0000000});

        rst = 1'b1; instr = '0; rs_data = '0; rt_data = '0; bubble = 1'b0;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            instr = vecs[i].instr; rs_data = vecs[i].rs; rt_data = vecs[i].rt; bubble = vecs[i].bubble;
            #1;
            check({vecs[i].name, ".aluctl"}, 32'(aluctl), 32'(vecs[i].e_aluctl));
            @(posedge clk);
            #1;
            check({vecs[i].name, ".res"},   alu_result_q, vecs[i].e_res);
            check({vecs[i].name, ".zero"},  32'(zero_q), 32'(vecs[i].e_zero));
            check({vecs[i].name, ".wrreg"}, 32'(wrreg_q), 32'(vecs[i].e_wrreg));
            check({vecs[i].name, ".flags"}, 32'(flags_now()), 32'(vecs[i].e_flags));
            @(negedge clk);
        end

        // Mid-cycle async reset: outputs clear well before the next edge.
        instr = itype(6'b100011, 5'd9, 16'hFFFC); rs_data = 32'd100; bubble = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst.res", alu_result_q, 32'd96);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        check("midrst.aluctl", 32'(aluctl), 32'(4'b0010));
        @(posedge clk);
        #1;
        check_all_zero("rst_held");

        // First edge after release captures normally: nor of 0,0.
        @(negedge clk);
        rst = 1'b0;
        instr = rtype(5'd10, 5'd2, 6'b100111); rs_data = '0; rt_data = '0;
        #1;
        check("nor0.aluctl", 32'(aluctl), 32'(4'b1100));
        @(posedge clk);
        #1;
        check("nor0.res",   alu_result_q, 32'hFFFFFFFF);
        check("nor0.zero",  32'(zero_q), 32'd0);
        check("nor0.wrreg", 32'(wrreg_q), 32'd10);
        check("nor0.flags", 32'(flags_now()), 32'(7'b1000010));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
